// File: rtl/div_pkg.sv
// Shared types and constants for the radix-2 restoring divider.
// Holds the FSM encoding, datapath widths and divide-by-zero quotient.
package div_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = 6;

  // Magnitude quotient when the divisor is zero: every trial
  // subtraction of zero succeeds, so every quotient bit is set.
  localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUO = '1;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    DIV  = 2'b01,
    DONE = 2'b10
  } div_state_e;

endpackage

// File: rtl/div_signfix.sv
// Conditional two's-complement negate: abs on input, sign restore on output.
// Ports: val_i value, neg_i negate when high, res_o result.
module div_signfix #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] val_i,
  input  logic             neg_i,
  output logic [WIDTH-1:0] res_o
);

  assign res_o = neg_i ? ('0 - val_i) : val_i;

endmodule

// File: rtl/div_unit.sv
// EX-stage multi-cycle restoring divider: LO=quotient, HI=remainder.
// Ports: clk, rst (async active-low), opdata1/opdata2 operands,
// div_valid/signed_div/annul controls, div_stall, div_done, lo_out, hi_out.
// Optional DIV_ZERO_FAST_EN: zero divisor completes one cycle after start.
module div_unit
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int ITER  = WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] opdata1,
  input  logic [WIDTH-1:0] opdata2,
  input  logic             div_valid,
  input  logic             signed_div,
  input  logic             annul,
  output logic             div_stall,
  output logic             div_done,
  output logic [WIDTH-1:0] lo_out,
  output logic [WIDTH-1:0] hi_out
);

  localparam logic [DIV_CNT_W-1:0] LAST =
    DIV_CNT_W'(ITER - 1);

  div_state_e state_q, state_d;
  logic [DIV_CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic negq_q, negq_d;
  logic negr_q, negr_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;

  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] q_fix, r_fix;
  logic [WIDTH:0]   sh;
  logic [WIDTH-1:0] trial;
  logic             ge;
  logic [WIDTH-1:0] rem_it, quo_it;

  div_signfix #(.WIDTH(WIDTH)) u_abs_a (
    .val_i (opdata1),
    .neg_i (signed_div & opdata1[WIDTH-1]),
    .res_o (a_mag)
  );

  div_signfix #(.WIDTH(WIDTH)) u_abs_b (
    .val_i (opdata2),
    .neg_i (signed_div & opdata2[WIDTH-1]),
    .res_o (b_mag)
  );

  div_signfix #(.WIDTH(WIDTH)) u_fix_q (
    .val_i (quo_d),
    .neg_i (negq_d),
    .res_o (q_fix)
  );

  div_signfix #(.WIDTH(WIDTH)) u_fix_r (
    .val_i (rem_d),
    .neg_i (negr_d),
    .res_o (r_fix)
  );

  // Shifted partial remainder needs WIDTH+1 bits; when it is
  // >= divisor the difference fits back into WIDTH bits.
  assign sh     = {rem_q, quo_q[WIDTH-1]};
  assign ge     = (sh >= {1'b0, dvs_q});
  assign trial  = sh[WIDTH-1:0] - dvs_q;
  assign rem_it = ge ? trial : sh[WIDTH-1:0];
  assign quo_it = {quo_q[WIDTH-2:0], ge};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    unique case (state_q)
      IDLE: begin
        if (div_valid && !annul) begin
          rem_d   = '0;
          quo_d   = a_mag;
          dvs_d   = b_mag;
          cnt_d   = '0;
          negq_d  = signed_div &
                    (opdata1[WIDTH-1] ^ opdata2[WIDTH-1]);
          negr_d  = signed_div & opdata1[WIDTH-1];
          state_d = DIV;
`ifdef DIV_ZERO_FAST_EN
          if (opdata2 == '0) begin
            quo_d   = WIDTH'(DIV_ZERO_QUO);
            rem_d   = a_mag;
            state_d = DONE;
          end
`endif
        end
      end
      DIV: begin
        rem_d = rem_it;
        quo_d = quo_it;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (annul) state_d = IDLE;
    // Results are registered on entry to DONE so they are
    // valid during the div_done cycle and held afterwards.
    if (state_d == DONE) begin
      lo_d = q_fix;
      hi_d = r_fix;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      lo_q    <= '0;
      hi_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
    end
  end

  assign div_stall = div_valid & ~annul & (state_q != DONE);
  assign div_done  = (state_q == DONE);
  assign lo_out    = lo_q;
  assign hi_out    = hi_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit with an expected-result queue.
// Checks reset, results, latency, stall, annul, back-to-back, mid-op reset.
module tb_div_unit;

  logic        clk;
  logic        rst;
  logic [31:0] opdata1;
  logic [31:0] opdata2;
  logic        div_valid;
  logic        signed_div;
  logic        annul;
  logic        div_stall;
  logic        div_done;
  logic [31:0] lo_out;
  logic [31:0] hi_out;

  typedef struct packed {
    logic [31:0] lo;
    logic [31:0] hi;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk;
  int   n_fail;

  div_unit dut (
    .clk        (clk),
    .rst        (rst),
    .opdata1    (opdata1),
    .opdata2    (opdata2),
    .div_valid  (div_valid),
    .signed_div (signed_div),
    .annul      (annul),
    .div_stall  (div_stall),
    .div_done   (div_done),
    .lo_out     (lo_out),
    .hi_out     (hi_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic [31:0] a,
                                input logic [31:0] b,
                                input logic s,
                                output logic [31:0] lo,
                                output logic [31:0] hi);
    longint la, lb;
    la = s ? longint'($signed(a)) : longint'(a);
    lb = s ? longint'($signed(b)) : longint'(b);
    if (b == 32'h0) begin
      hi = a;
      lo = (s && a[31]) ? 32'h1 : 32'hFFFF_FFFF;
    end else begin
      lo = 32'(la / lb);
      hi = 32'(la % lb);
    end
  endfunction

  function automatic int exp_lat(input logic [31:0] b);
    int l;
    l = 33;
`ifdef DIV_ZERO_FAST_EN
    if (b == 32'h0) l = 1;
`endif
    return l;
  endfunction

  task automatic push_exp(input logic [31:0] a,
                          input logic [31:0] b,
                          input logic s);
    exp_t e;
    model(a, b, s, e.lo, e.hi);
    sb_q.push_back(e);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (div_done) begin
      if (sb_q.size() == 0) begin
        chk("spurious_done", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk("lo", lo_out, e.lo);
        chk("hi", hi_out, e.hi);
      end
    end
  end

  task automatic wait_done(output int n, inout int sc);
    for (n = 1; n <= 200; n++) begin
      @(posedge clk);
      #1;
      if (div_done) return;
      if (div_stall) sc++;
    end
    chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_op(input logic [31:0] a,
                        input logic [31:0] b,
                        input logic s);
    int n, sc;
    push_exp(a, b, s);
    opdata1    = a;
    opdata2    = b;
    signed_div = s;
    div_valid  = 1'b1;
    #1;
    sc = div_stall ? 1 : 0;
    wait_done(n, sc);
    chk("latency", n, exp_lat(b));
    chk("stall_cyc", sc, exp_lat(b));
    chk("stall_in_done", {31'b0, div_stall}, 32'd0);
    div_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, sc;
    n_chk      = 0;
    n_fail     = 0;
    rst        = 1'b0;
    opdata1    = '0;
    opdata2    = '0;
    div_valid  = 1'b0;
    signed_div = 1'b0;
    annul      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_lo", lo_out, 32'h0);
    chk("rst_hi", hi_out, 32'h0);
    chk("rst_done", {31'b0, div_done}, 32'h0);
    chk("rst_stall", {31'b0, div_stall}, 32'h0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    run_op(32'd100, 32'd7, 1'b0);
    run_op(32'hFFFF_FFF9, 32'h2, 1'b1);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    run_op(32'd5, 32'd0, 1'b0);
    run_op(32'hFFFF_FFFB, 32'd0, 1'b1);
    run_op(32'd5, 32'd0, 1'b1);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0);

    // annul ten edges after the request edge
    opdata1    = 32'd100;
    opdata2    = 32'd7;
    signed_div = 1'b0;
    div_valid  = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    annul = 1'b1;
    #1;
    chk("stall_annul", {31'b0, div_stall}, 32'd0);
    @(posedge clk);
    #1;
    annul     = 1'b0;
    div_valid = 1'b0;
    chk("done_annul", {31'b0, div_done}, 32'd0);
    run_op(32'd1000, 32'd10, 1'b0);

    // back-to-back: valid held across DONE with new operands
    push_exp(32'd100, 32'd7, 1'b0);
    push_exp(32'hDEAD_BEEF, 32'h1234, 1'b1);
    opdata1    = 32'd100;
    opdata2    = 32'd7;
    signed_div = 1'b0;
    div_valid  = 1'b1;
    sc = 0;
    wait_done(n, sc);
    chk("b2b_first", n, 32'd33);
    opdata1    = 32'hDEAD_BEEF;
    opdata2    = 32'h1234;
    signed_div = 1'b1;
    wait_done(n, sc);
    chk("b2b_gap", n, 32'd34);
    div_valid = 1'b0;
    @(posedge clk);
    #1;

    // reset in the middle of an iteration
    opdata1    = 32'd100;
    opdata2    = 32'd7;
    signed_div = 1'b0;
    div_valid  = 1'b1;
    repeat (20) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_lo", lo_out, 32'h0);
    chk("mid_rst_hi", hi_out, 32'h0);
    chk("mid_rst_done", {31'b0, div_done}, 32'h0);
    div_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    run_op(32'd9, 32'd3, 1'b0);

    for (int i = 0; i < 6; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = ($urandom_range(0, 2) == 0) ?
          32'($urandom_range(0, 9)) : $urandom;
      run_op(a, b, i[0]);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", sb_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d",
             n_chk, n_fail);
    $finish;
  end

endmodule
